bf_loader: RTL

Program loader for the brainhack core. Accepts an ASCII Brainfuck source stream one byte per handshake and encodes each command into the core's 3-bit opcode. Writes the opcodes sequentially into program memory and validates bracket nesting against the core's stack depth. It drives the write port of program memory; the core reads the same memory through its fetch port.

---
 rtl/bf_loader_pkg.sv | 29 ++
 rtl/bf_loader_if.sv | 11 +
 rtl/bf_loader_char_decode.sv | 32 +++
 rtl/bf_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bf_loader_pkg.sv
// Shared definitions for the brainhack program loader: FSM states,
// 3-bit core opcodes, abort codes and the source terminator byte.
package bf_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILL  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP        = 3'b000;
  localparam logic [2:0] OP_TAPE_INC   = 3'b010;
  localparam logic [2:0] OP_TAPE_DEC   = 3'b011;
  localparam logic [2:0] OP_PTR_INC    = 3'b100;
  localparam logic [2:0] OP_PTR_DEC    = 3'b101;
  localparam logic [2:0] OP_LOOP_OPEN  = 3'b110;
  localparam logic [2:0] OP_LOOP_CLOSE = 3'b111;

  localparam logic [2:0] ERR_NONE            = 3'd0;
  localparam logic [2:0] ERR_UNMATCHED_CLOSE = 3'd1;
  localparam logic [2:0] ERR_UNMATCHED_OPEN  = 3'd2;
  localparam logic [2:0] ERR_DEPTH_OVF       = 3'd3;
  localparam logic [2:0] ERR_TOO_LONG        = 3'd4;

  localparam logic [7:0] CH_END = 8'h00;

endpackage

// File: rtl/bf_loader_if.sv
// Source byte stream into the loader, one ASCII byte per handshake.
interface bf_loader_if;
  // A byte transfers on a cycle where i_char_valid && o_char_ready; the
  // source holds i_char stable while valid is high and ready is low.
  logic       i_char_valid;
  logic [7:0] i_char;
  logic       o_char_ready;

  modport master (output i_char_valid, output i_char, input o_char_ready);
  modport slave  (input i_char_valid, input i_char, output o_char_ready);
endinterface

// File: rtl/bf_loader_char_decode.sv
// Combinational classifier: maps one source byte to its core opcode and
// flags whether it is a command, a loop bracket or the terminator.
module bf_loader_char_decode
  import bf_loader_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_cmd,
  output logic       o_is_end,
  output logic       o_is_open,
  output logic       o_is_close,
  output logic [2:0] o_opcode
);

  always_comb begin
    o_is_cmd   = 1'b1;
    o_is_end   = 1'b0;
    o_is_open  = 1'b0;
    o_is_close = 1'b0;
    o_opcode   = OP_NOP;
    case (i_char)
      8'h2B: o_opcode = OP_TAPE_INC;
      8'h2D: o_opcode = OP_TAPE_DEC;
      8'h3E: o_opcode = OP_PTR_INC;
      8'h3C: o_opcode = OP_PTR_DEC;
      8'h5B: begin o_opcode = OP_LOOP_OPEN;  o_is_open  = 1'b1; end
      8'h5D: begin o_opcode = OP_LOOP_CLOSE; o_is_close = 1'b1; end
      CH_END: begin o_is_cmd = 1'b0; o_is_end = 1'b1; end
      default: o_is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_loader.sv
// Brainfuck program loader: encodes source bytes into opcodes, writes them
// to program memory and checks bracket nesting. BF_LOADER_CLEAR_EN builds the
// FILL state that NOP-clears memory past the end of the program.
module bf_loader
  import bf_loader_pkg::*;
#(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH       = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  bf_loader_if.slave                   char_if,
  output logic                         o_prgmem_in,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [2:0]                   o_error_code,
  output logic [PRGMEM_ADDR_WIDTH:0]   o_length,
  output state_t                       o_dbg_state
);

  localparam int AW = PRGMEM_ADDR_WIDTH;
  localparam int SW = STACK_ADDR_WIDTH;
  localparam logic [AW:0]   FULL_LEN  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LEN_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [SW:0]   MAX_DEPTH = {1'b1, {SW{1'b0}}};
  localparam logic [SW:0]   DEPTH_ONE = {{SW{1'b0}}, 1'b1};

  state_t                 r_state, w_state_next;
  logic                   r_prgmem_in, w_prgmem_in_next;
  logic [AW-1:0]          r_prgmem_addr, w_prgmem_addr_next;
  logic [INSTR_WIDTH-1:0] r_prgmem_data, w_prgmem_data_next;
  logic [AW-1:0]          r_addr, w_addr_next;
  logic [AW:0]            r_length, w_length_next;
  logic [SW:0]            r_depth, w_depth_next;
  logic                   r_done, w_done_next;
  logic                   r_error, w_error_next;
  logic [2:0]             r_error_code, w_error_code_next;

  logic       w_ready, w_accept;
  logic       w_is_cmd, w_is_end, w_is_open, w_is_close;
  logic [2:0] w_opcode;

  bf_loader_char_decode u_decode (
    .i_char     (char_if.i_char),
    .o_is_cmd   (w_is_cmd),
    .o_is_end   (w_is_end),
    .o_is_open  (w_is_open),
    .o_is_close (w_is_close),
    .o_opcode   (w_opcode)
  );

  assign w_ready              = (r_state == S_LOAD);
  assign w_accept             = char_if.i_char_valid && w_ready;
  assign char_if.o_char_ready = w_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_prgmem_in   <= 1'b0;
      r_prgmem_addr <= '0;
      r_prgmem_data <= '0;
      r_addr        <= '0;
      r_length      <= '0;
      r_depth       <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_error_code  <= ERR_NONE;
    end else begin
      r_state       <= w_state_next;
      r_prgmem_in   <= w_prgmem_in_next;
      r_prgmem_addr <= w_prgmem_addr_next;
      r_prgmem_data <= w_prgmem_data_next;
      r_addr        <= w_addr_next;
      r_length      <= w_length_next;
      r_depth       <= w_depth_next;
      r_done        <= w_done_next;
      r_error       <= w_error_next;
      r_error_code  <= w_error_code_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_prgmem_in_next   = 1'b0;
    w_prgmem_addr_next = r_prgmem_addr;
    w_prgmem_data_next = r_prgmem_data;
    w_addr_next        = r_addr;
    w_length_next      = r_length;
    w_depth_next       = r_depth;
    w_done_next        = r_done;
    w_error_next       = r_error;
    w_error_code_next  = r_error_code;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_state_next      = S_LOAD;
          w_addr_next       = '0;
          w_length_next     = '0;
          w_depth_next      = '0;
          w_done_next       = 1'b0;
          w_error_next      = 1'b0;
          w_error_code_next = ERR_NONE;
        end
      end
      S_LOAD: begin
        if (w_accept && w_is_cmd) begin
          // Abort checks are ordered so a full memory wins over bracket faults.
          if (r_length == FULL_LEN) begin
            w_state_next      = S_ERROR;
            w_error_next      = 1'b1;
            w_error_code_next = ERR_TOO_LONG;
          end else if (w_is_open && r_depth == MAX_DEPTH) begin
            w_state_next      = S_ERROR;
            w_error_next      = 1'b1;
            w_error_code_next = ERR_DEPTH_OVF;
          end else if (w_is_close && r_depth == '0) begin
            w_state_next      = S_ERROR;
            w_error_next      = 1'b1;
            w_error_code_next = ERR_UNMATCHED_CLOSE;
          end else begin
            w_prgmem_in_next   = 1'b1;
            w_prgmem_addr_next = r_addr;
            w_prgmem_data_next = INSTR_WIDTH'(w_opcode);
            w_addr_next        = r_addr + ADDR_ONE;
            w_length_next      = r_length + LEN_ONE;
            if (w_is_open)       w_depth_next = r_depth + DEPTH_ONE;
            else if (w_is_close) w_depth_next = r_depth - DEPTH_ONE;
          end
        end else if (w_accept && w_is_end) begin
          if (r_depth != '0) begin
            w_state_next      = S_ERROR;
            w_error_next      = 1'b1;
            w_error_code_next = ERR_UNMATCHED_OPEN;
          end else begin
`ifdef BF_LOADER_CLEAR_EN
            if (r_length == FULL_LEN) begin
              w_state_next = S_DONE;
              w_done_next  = 1'b1;
            end else begin
              // The first NOP is issued with the terminator so fill k lands at T+1+k.
              w_state_next       = S_FILL;
              w_prgmem_in_next   = 1'b1;
              w_prgmem_addr_next = r_addr;
              w_prgmem_data_next = INSTR_WIDTH'(OP_NOP);
              w_addr_next        = r_addr + ADDR_ONE;
            end
`else
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
`endif
          end
        end
      end
`ifdef BF_LOADER_CLEAR_EN
      S_FILL: begin
        // The address wrapping to zero means the top word was just written.
        if (r_addr == '0) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_prgmem_in_next   = 1'b1;
          w_prgmem_addr_next = r_addr;
          w_prgmem_data_next = INSTR_WIDTH'(OP_NOP);
          w_addr_next        = r_addr + ADDR_ONE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_prgmem_in   = r_prgmem_in;
  assign o_prgmem_addr = r_prgmem_addr;
  assign o_prgmem_data = r_prgmem_data;
  assign o_busy        = (r_state == S_LOAD) || (r_state == S_FILL);
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_error_code  = r_error_code;
  assign o_length      = r_length;
  assign o_dbg_state   = r_state;

endmodule
